hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit operands and 32-bit HI/LO.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  multiply/divide request from execute stage; level, held while stalled.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a, b  in  32 each  rs/rt operands (dividend/divisor for divide).
REQ-007 mthi, mtlo  in  1 each  hiloregwrite qualifiers from the controller.
REQ-008 wdata  in  32  data for mthi/mtlo.
REQ-009 flush  in  1  pipeline flush of the execute stage; aborts the operation.
REQ-010 hi, lo  out  32 each  architectural HI/LO registers (MFHI/MFLO read source).
REQ-011 stall  out  1  stall request to the hazard unit.
REQ-012 busy  out  1  state != IDLE.
REQ-013 done  out  1  one-cycle pulse in the result cycle.
REQ-014 dz  out  1  one-cycle pulse with done when a divide had b == 0.

Function
REQ-015 FSM states: IDLE, CALC, DONE; encoding free.
REQ-016 IDLE: start=1 and flush=0 -> latch |a|, |b|, op, result sign bits; clear iteration count; go to CALC.
REQ-017 CALC: exactly one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); after 32 steps go to DONE.
REQ-018 DONE: done=1; on the exiting edge write HI/LO, go to IDLE.
REQ-019 Latency: start sampled at edge E0 -> new HI/LO visible after edge E33; busy high for 33 cycles.
REQ-020 stall = (IDLE & start & ~flush) | CALC; low in DONE so the instruction advances at E33.
REQ-021 Start held high while in DONE is not re-accepted; a new operation needs start in IDLE.
REQ-022 MULT/MULTU: {HI,LO} = 64-bit product; MULT negates the magnitude product when sign(a) XOR sign(b).
REQ-023 DIV/DIVU: LO = quotient, HI = remainder.
REQ-024 DIV signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); truncation toward zero.
REQ-025 Magnitude of 0x80000000 is handled as unsigned 2^31, so no overflow occurs in the datapath.
REQ-026 Divide with b == 0: full latency, HI/LO not written, dz=1 with done.
REQ-027 mthi/mtlo write wdata to HI/LO at the edge only in IDLE with start=0.
REQ-028 mthi/mtlo conflicts: ignored when start=1, in CALC, or in DONE; the result write wins.
REQ-029 mthi and mtlo together write both registers.
REQ-030 flush in CALC or DONE: go to IDLE next edge; HI/LO unchanged; done/dz suppressed that cycle.
REQ-031 flush in IDLE blocks acceptance of start.
REQ-032 hi/lo are driven directly from registers; no combinational path from a, b, or wdata.

Reset
REQ-033 rst asserted, at any state and mid-operation: state=IDLE, count=0, hi=0, lo=0, busy=0, stall=0, done=0, dz=0.
REQ-034 rst asserted mid-operation: partial results are discarded and HI/LO are not updated.
REQ-035 rst deassertion: first start accepted at the first rising edge after deassertion.

Verification
REQ-036 MULT a=0xFFFFFFFD (-3), b=5 -> after E33 hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall high for 33 cycles (E0 cycle through CALC), done pulse once.
REQ-037 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 DIVU b=0 with prior hi=0x11, lo=0x22 -> dz=done=1 in DONE; hi/lo stay 0x11/0x22.
REQ-040 mthi wdata=0xAAAA5555 during CALC is ignored; mtlo wdata=0x1234 in IDLE -> lo=0x1234 next edge.
REQ-041 flush at CALC step 10 -> IDLE next edge, no done, hi/lo unchanged; rst at step 20 -> hi=lo=0, busy=0 immediately, asynchronously.

Source files
------------

// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide on magnitudes.
module hilo_mdu (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic        dz,
   output logic [1:0]  dbg_state
);

   // Handshake: start is a level held by the execute stage while stall is high;
   // the operation is accepted on the edge where IDLE & start & ~flush holds, and
   // done marks the single cycle in which the instruction may leave execute.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;

   logic [31:0] hi_q, lo_q;
   logic        is_div_q;
   logic [31:0] mcand_q;
   logic [31:0] acc_hi_q;
   logic [31:0] acc_lo_q;
   logic        neg_q;
   logic        rneg_q;
   logic        bz_q;

   logic        accept;
   logic        write_res;
   logic        mt_ok;

   // Operand conditioning: only MULT/DIV (op[0]==0) treat operands as signed.
   logic        sa, sb;
   logic [31:0] abs_a, abs_b;

   assign sa    = a[31] & ~op[0];
   assign sb    = b[31] & ~op[0];
   assign abs_a = sa ? (32'd0 - a) : a;
   assign abs_b = sb ? (32'd0 - b) : b;

   // Multiply step: conditional add of the multiplicand, then shift right.
   logic [32:0] mul_sum;
   logic [31:0] mul_hi_nx, mul_lo_nx;

   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign mul_hi_nx = mul_sum[32:1];
   assign mul_lo_nx = {mul_sum[0], acc_lo_q[31:1]};

   // Divide step: shift the next dividend bit into the remainder and try subtract.
   logic [32:0] div_sh;
   logic [31:0] div_diff;
   logic        div_ok;
   logic [31:0] div_hi_nx, div_lo_nx;

   assign div_sh    = {acc_hi_q, acc_lo_q[31]};
   assign div_ok    = (div_sh >= {1'b0, mcand_q});
   assign div_diff  = div_sh[31:0] - mcand_q;
   assign div_hi_nx = div_ok ? div_diff : div_sh[31:0];
   assign div_lo_nx = {acc_lo_q[30:0], div_ok};

   // Result sign correction applied only when HI/LO are written.
   logic [63:0] prod_s;
   logic [31:0] quo_s, rem_s;
   logic [31:0] res_hi, res_lo;

   assign prod_s = neg_q  ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
   assign quo_s  = neg_q  ? (32'd0 - acc_lo_q) : acc_lo_q;
   assign rem_s  = rneg_q ? (32'd0 - acc_hi_q) : acc_hi_q;
   assign res_hi = is_div_q ? rem_s : prod_s[63:32];
   assign res_lo = is_div_q ? quo_s : prod_s[31:0];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               state_d = S_CALC;
               cnt_d   = 6'd0;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      accept    = 1'b0;
      write_res = 1'b0;
      mt_ok     = 1'b0;
      busy      = 1'b0;
      stall     = 1'b0;
      done      = 1'b0;
      dz        = 1'b0;
      case (state_q)
         S_IDLE: begin
            accept = start & ~flush;
            mt_ok  = ~start;
            stall  = ~rst & start & ~flush;
         end
         S_CALC: begin
            busy  = 1'b1;
            stall = ~rst;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = ~flush;
            dz        = ~flush & is_div_q & bz_q;
            write_res = ~flush & ~(is_div_q & bz_q);
         end
         default: ;
      endcase
   end

   // Iterative datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_div_q <= 1'b0;
         mcand_q  <= 32'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         bz_q     <= 1'b0;
      end else if (accept) begin
         is_div_q <= op[1];
         mcand_q  <= abs_b;
         acc_hi_q <= 32'd0;
         acc_lo_q <= abs_a;
         neg_q    <= sa ^ sb;
         rneg_q   <= sa;
         bz_q     <= (b == 32'd0);
      end else if (state_q == S_CALC) begin
         if (is_div_q) begin
            acc_hi_q <= div_hi_nx;
            acc_lo_q <= div_lo_nx;
         end else begin
            acc_hi_q <= mul_hi_nx;
            acc_lo_q <= mul_lo_nx;
         end
      end
   end

   // Architectural HI/LO: a result write always takes priority over mthi/mtlo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (write_res) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (mt_ok) begin
         if (mthi) hi_q <= wdata;
         if (mtlo) lo_q <= wdata;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed + random bench for hilo_mdu; expected HI/LO come from a software model
// through a scoreboard queue and are compared when done is observed.
module tb_hilo_mdu;

   logic        clk = 1'b0;
   logic        rst, start, mthi, mtlo, flush;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic [31:0] hi, lo;
   logic        stall, busy, done, dz;
   logic [1:0]  dbg_state;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   hilo_mdu dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
      .hi(hi), .lo(lo), .stall(stall), .busy(busy), .done(done), .dz(dz),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference model: returns {HI,LO}; a divide by zero leaves prev unchanged.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] prev);
      longint      sp, sq, sr;
      logic [63:0] ux, uy, r;
      logic [63:0] tq, tr;
      ux = {32'd0, x};
      uy = {32'd0, y};
      r  = prev;
      case (o)
         2'b00: begin
            sp = longint'($signed(x)) * longint'($signed(y));
            r  = sp;
         end
         2'b01: r = ux * uy;
         2'b10: if (y != 32'd0) begin
            sq = longint'($signed(x)) / longint'($signed(y));
            sr = longint'($signed(x)) % longint'($signed(y));
            tq = sq;
            tr = sr;
            r  = {tr[31:0], tq[31:0]};
         end
         default: if (y != 32'd0) r = {x % y, x / y};
      endcase
      return r;
   endfunction

   // driver: one full operation with start held until the instruction advances
   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit inj);
      logic [63:0] e, got_v;
      int          stall_cnt, busy_cnt;
      bit          got;
      e = model(o, av, bv, {m_hi, m_lo});
      exp_q.push_back(e);
      start = 1'b1; op = o; a = av; b = bv;
      #1;
      check("stall_e0", stall, 1);
      stall_cnt = 1;
      busy_cnt  = 0;
      got       = 0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (busy) busy_cnt++;
         if (inj && c == 6) begin
            mthi = 1'b0;
            check("mthi_calc_ignored", hi, m_hi);
         end
         if (inj && c == 5) begin
            mthi  = 1'b1;
            wdata = 32'hAAAA5555;
         end
         if (done) begin
            got = 1;
            check("done_cycle", c, 33);
            check("dz", dz, (o[1] && bv == 32'd0));
         end
      end
      check("done_seen", got, 1);
      check("stall_cycles", stall_cnt, 33);
      check("busy_cycles", busy_cnt, 33);
      @(negedge clk);
      check("no_reaccept", busy, 0);
      start = 1'b0;
      if (exp_q.size() > 0) begin
         got_v = exp_q.pop_front();
         check("hilo", {hi, lo}, got_v);
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   task automatic mt(input logic hen, input logic len, input logic [31:0] d);
      mthi = hen; mtlo = len; wdata = d;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      if (hen) m_hi = d;
      if (len) m_lo = d;
      check("mt_hilo", {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      int  dcnt;
      bit  got;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; flush = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_busy", busy, 0);
      check("rst_done", {done, dz}, 0);
      start = 1'b1;
      #1;
      check("rst_stall", stall, 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // arithmetic vectors; the first start lands on the first edge after reset
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1);
      run_op(2'b11, 32'd100, 32'd7, 1'b0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0);
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0);

      // move-to registers
      mt(1'b0, 1'b1, 32'h00001234);
      mt(1'b1, 1'b1, 32'hCAFEF00D);
      mt(1'b1, 1'b0, 32'h00000011);
      mt(1'b0, 1'b1, 32'h00000022);

      // divide by zero keeps HI/LO
      run_op(2'b11, 32'd55, 32'd0, 1'b0);
      run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0);

      // mtlo with start high is ignored
      start = 1'b1; flush = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A5A5A;
      #1;
      check("flush_idle_stall", stall, 0);
      @(negedge clk);
      check("flush_idle_busy", busy, 0);
      check("mt_start_ignored", lo, m_lo);
      start = 1'b0; flush = 1'b0; mtlo = 1'b0;

      // flush at CALC step 10
      start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
      for (int i = 0; i < 11; i++) @(negedge clk);
      check("flush_calc_busy_before", busy, 1);
      flush = 1'b1; start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check("flush_calc_idle", busy, 0);
      dcnt = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("flush_calc_no_done", dcnt, 0);
      check("flush_calc_hilo", {hi, lo}, {m_hi, m_lo});

      // flush in DONE suppresses done and the write
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      check("flush_done_reached", got, 1);
      flush = 1'b1;
      #1;
      check("flush_done_suppress", {done, dz}, 0);
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check("flush_done_idle", busy, 0);
      check("flush_done_hilo", {hi, lo}, {m_hi, m_lo});

      // asynchronous reset at step 20
      mt(1'b1, 1'b1, 32'hDEADBEEF);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      for (int i = 0; i < 21; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      check("rst_mid_busy_stall", {busy, stall}, 0);
      start = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_after", {hi, lo, 31'd0, busy}, {m_hi, m_lo, 32'd0});

      // random operations
      for (int i = 0; i < 8; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         run_op(ro, ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
